// File: rtl/unsigned_seq_mul_rs.sv
// rtl/unsigned_seq_mul_rs.sv - sequential unsigned right-shift shift-and-add multiplier
//
// Purpose: multiplies two N-bit unsigned operands over N clock cycles, one
// add/shift iteration per rising edge, using an accumulator/multiplier pair
// that shifts right together. A one-cycle load pulse samples the operands and
// (re)starts the computation; done flags the final product.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   load    - start pulse; a and b are sampled on the edge where load=1
//   a       - multiplicand (unsigned, N bits)
//   b       - multiplier (unsigned, N bits)
//   product - registered {ACC, Q}; equals a*b when done=1
//   done    - high while product holds the final result

module unsigned_seq_mul_rs #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  logic [N-1:0]  r_m;
  logic [N-1:0]  r_acc;
  logic          r_c;
  logic [N-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  // Carry-extended partial sum {C, ACC}; the multiplicand is added only when
  // the current multiplier LSB is set.
  logic [N:0]    w_sum;

  always_comb begin
    w_sum = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_m : {N{1'b0}})};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m    <= '0;
      r_acc  <= '0;
      r_c    <= 1'b0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (load) begin
      // Load wins over an in-flight iteration, so a new pulse aborts and restarts.
      r_m    <= a;
      r_q    <= b;
      r_acc  <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      // Shift {C, sum, Q} right by one: the sum's LSB drops into Q's MSB and
      // the carry position refills with zero.
      r_c   <= 1'b0;
      r_acc <= w_sum[N:1];
      r_q   <= {w_sum[0], r_q[N-1:1]};
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST_CNT) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign product = {r_acc, r_q};
  assign done    = r_done;

endmodule

// File: tb/tb_unsigned_seq_mul_rs.sv
// tb/tb_unsigned_seq_mul_rs.sv - self-checking bench for unsigned_seq_mul_rs

module tb_unsigned_seq_mul_rs;

  localparam int N = 6;

  logic           clk;
  logic           rst;
  logic           load;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] product;
  logic           done;

  int checks;
  int failures;

  unsigned_seq_mul_rs #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .a       (a),
    .b       (b),
    .product (product),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // After k iterations the low k multiplier bits have been consumed: their
  // partial product sits left-aligned at bit N-k, and the unconsumed
  // multiplier bits occupy the bottom N-k bits.
  function automatic logic [2*N-1:0] model(input int ma, input int mb, input int k);
    int lowmask;
    int p;
    lowmask = (1 << k) - 1;
    p = ((ma * (mb & lowmask)) << (N - k)) | (mb >> k);
    return p[2*N-1:0];
  endfunction

  task automatic do_load(input int la, input int lb);
    @(negedge clk);
    load = 1'b1;
    a    = la[N-1:0];
    b    = lb[N-1:0];
    @(posedge clk);
    #1;
    check("load_product", product, model(la, lb, 0));
    check("load_done", done, 0);
    load = 1'b0;
  endtask

  // Runs nsteps iteration edges from step 'from'; optionally scrambles operands.
  task automatic run_steps(input int la, input int lb, input int from, input int nsteps,
                           input bit chg);
    for (int k = from + 1; k <= from + nsteps; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("step%0d_product(%0d*%0d)", k, la, lb), product, model(la, lb, k));
      check($sformatf("step%0d_done", k), done, (k == N) ? 1 : 0);
      if (chg) begin
        a = N'($urandom);
        b = N'($urandom);
      end
    end
  endtask

  task automatic full_op(input int la, input int lb, input bit chg);
    do_load(la, lb);
    run_steps(la, lb, 0, N, chg);
    check($sformatf("final(%0d*%0d)", la, lb), product, la * lb);
  endtask

  task automatic hold_check(input int edges, input logic [2*N-1:0] expp, input logic expd);
    for (int i = 0; i < edges; i++) begin
      @(posedge clk);
      #1;
      check("hold_product", product, expp);
      check("hold_done", done, expd);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    load = 1'b0;
    a    = '0;
    b    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_product", product, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    hold_check(2, 12'h000, 1'b0);

    // Max case with explicit first-edge value and hold afterwards.
    do_load(63, 63);
    @(posedge clk);
    #1;
    check("max_step1", product, 12'h7FF);
    run_steps(63, 63, 1, N - 1, 1'b0);
    check("max_final", product, 12'hF81);
    check("max_done", done, 1);
    hold_check(5, 12'hF81, 1'b1);

    full_op(0, 42, 1'b0);
    full_op(21, 0, 1'b0);
    full_op(1, 63, 1'b0);
    full_op(42, 21, 1'b0);
    full_op(32, 2, 1'b0);

    // Restart mid-operation.
    do_load(63, 63);
    run_steps(63, 63, 0, 3, 1'b0);
    full_op(5, 7, 1'b0);
    check("restart_final", product, 35);

    // Asynchronous reset mid-operation.
    do_load(63, 63);
    run_steps(63, 63, 0, 2, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_product", product, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    hold_check(4, 12'h000, 1'b0);

    // Operands changing during the run must not matter.
    full_op(10, 12, 1'b1);
    check("opchg_final", product, 120);

    // Randomized operands, some with operands scrambled during computation.
    for (int t = 0; t < 30; t++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(0, 63));
      rb = int'($urandom_range(0, 63));
      full_op(ra, rb, t[0]);
    end
    hold_check(3, product, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unsigned_seq_mul_rs.md
Name: unsigned_seq_mul_rs

Overview:
Sequential unsigned shift-and-add multiplier using the right-shift accumulator/multiplier method. It multiplies two 6-bit unsigned operands and produces a 12-bit product. It uses one add/shift iteration per clock. It is a standalone arithmetic datapath block, started by a one-cycle load pulse, that replaces a combinational multiplier where area matters more than latency.

Parameters:
- N, 6, operand width; product width is 2N. Default N=6 is the required configuration; other values are optional.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- load  input  1  start pulse; operands sampled on the rising clk edge where load=1
- a  input  6  multiplicand (unsigned)
- b  input  6  multiplier (unsigned)
- product  output  12  registered product register {ACC, Q}; holds a*b once complete
- done  output  1  high when product holds the final result; optional to connect

Behaviour:
- Internal state:
  - M[5:0]: multiplicand.
  - ACC[5:0]: upper half.
  - C: carry bit.
  - Q[5:0]: multiplier / lower half.
  - cnt[2:0]: iteration counter.
  - busy flag.
- Reset (rst=1, asynchronous, any time including mid-operation):
  - M, ACC, C, Q, cnt all clear to 0.
  - busy=0, done=0, product=0.
- Load edge (posedge clk, load=1):
  - M<=a, Q<=b, ACC<=0, C<=0, cnt<=0, busy<=1, done<=0.
  - product after this edge = {6'b0, b}.
  - No add or shift happens on the load edge.
- Iteration edge (posedge clk, load=0, busy=1):
  - {C,ACC} = ACC + (Q[0] ? M : 0), a 7-bit sum.
  - Then {C,ACC,Q} shifts right by 1; 0 enters the MSB.
  - cnt increments.
  - When cnt reaches N (6th iteration edge): busy<=0, done<=1.
- Latency: the result is valid after exactly 6 rising edges following the load edge. done rises on the 6th.
- Idle (busy=0, load=0): all registers hold; product and done stable indefinitely.
- load has priority over iteration. Asserting load mid-operation aborts and restarts with the new operands.
- a and b are ignored except on load edges. They may change freely during computation.
- Arithmetic: unsigned only. The maximum product is 63*63=3969 (12'hF81); no overflow is possible in 12 bits.
- product is intermediate (partial sum in the upper bits, remaining multiplier in the lower bits) while busy. It is meaningful only when done=1.

Test Plan:
- 63*63 max case:
  - Reset, then load a=6'h3F, b=6'h3F.
  - After the 1st iteration edge: product=12'h7FF.
  - After the 6th edge: product=12'hF81 (3969), done=1.
  - Product stays unchanged over 5 further edges.
- Zero operand:
  - a=0, b=6'h2A -> product=0 after 6 edges.
  - a=6'h15, b=0 -> product=0 after 6 edges, done=1.
- Mixed values:
  - 1*63 -> 63 (12'h03F).
  - 42*21 -> 882 (12'h372).
  - 32*2 -> 64.
  - done=0 for edges 1-5, 1 on edge 6.
- Restart mid-operation:
  - Load 63*63, run 3 edges, then load 5*7.
  - After 6 more edges: product=35, done=1.
- Reset mid-operation:
  - Load 63*63, run 2 edges, assert rst asynchronously (not on a clk edge).
  - product=0 and done=0 immediately.
  - After rst is released, no further change until the next load.
- Operand change during run: load 10*12, change a/b every cycle afterwards -> product=120.
